// File: rtl/logic_unit_pkg.sv
// Shared definitions for the datapath logic unit: operation encodings and
// flag bit positions used by the ALU flag register.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_PARITY = 1;
    localparam int FLAG_W      = 2;

endpackage

// File: rtl/nbit_logic_core.sv
// Combinational N-bit logic core: every bit computes all eight gate results
// and an 8:1 mux on op picks one.
module nbit_logic_core
    import logic_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] x,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            wire [7:0] r;
            wire       nb;

            and  u_and  (r[OP_AND],  x[i], b[i]);
            or   u_or   (r[OP_OR],   x[i], b[i]);
            xor  u_xor  (r[OP_XOR],  x[i], b[i]);
            nor  u_nor  (r[OP_NOR],  x[i], b[i]);
            nand u_nand (r[OP_NAND], x[i], b[i]);
            xnor u_xnor (r[OP_XNOR], x[i], b[i]);
            not  u_not  (nb, b[i]);
            and  u_andn (r[OP_ANDN], x[i], nb);
            assign r[OP_PASS] = b[i];

            assign y[i] = r[op];
        end
    endgenerate

endmodule

// File: rtl/nbit_logic_acc.sv
// Registered N-bit logic unit with optional accumulator operand, zero/parity
// flags and a one-deep valid/ready output stage.
module nbit_logic_acc
    import logic_unit_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] ACC_INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic         acc_mode,
    input  logic         acc_clr,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         parity
);

    logic [N-1:0]      acc;
    logic [N-1:0]      x;
    logic [N-1:0]      y;
    logic              fire;
    logic [FLAG_W-1:0] flags_d;

    // Handshake: a beat transfers on any edge where valid && ready. The input
    // side is ready whenever the output slot is empty or being drained, so a
    // consume and a new fire in the same cycle replace the beat with no bubble.
    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;
    assign x        = acc_mode ? acc : a;

    nbit_logic_core #(.N(N)) u_core (
        .op (op),
        .x  (x),
        .b  (b),
        .y  (y)
    );

    // Flags are derived from the value being loaded, not the held result.
    always_comb begin
        flags_d              = '0;
        flags_d[FLAG_ZERO]   = (y == '0);
        flags_d[FLAG_PARITY] = ^y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            acc       <= ACC_INIT;
        end else if (fire) begin
            out_valid <= 1'b1;
            result    <= y;
            zero      <= flags_d[FLAG_ZERO];
            parity    <= flags_d[FLAG_PARITY];
            if (acc_mode) begin
                acc <= y;
            end
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A clear colliding with a fire is dropped; only idle clears land.
            if (acc_clr) begin
                acc <= ACC_INIT;
            end
        end
    end

endmodule

// File: tb/tb_nbit_logic_acc.sv
// Randomized and directed bench for nbit_logic_acc against a queue-based
// reference model of the output slot and accumulator.
module tb_nbit_logic_acc;
    import logic_unit_pkg::*;

    localparam int          N        = 32;
    localparam logic [31:0] ACC_INIT = 32'h0;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        acc_mode;
    logic        acc_clr;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        parity;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic [31:0] m_acc;
    logic [31:0] m_last;

    nbit_logic_acc #(.N(N), .ACC_INIT(ACC_INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] xv,
                                           input logic [31:0] bv);
        case (o)
            3'd0:    return xv & bv;
            3'd1:    return xv | bv;
            3'd2:    return xv ^ bv;
            3'd3:    return ~(xv | bv);
            3'd4:    return ~(xv & bv);
            3'd5:    return ~(xv ^ bv);
            3'd6:    return xv & ~bv;
            default: return bv;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [2:0] o, input logic am, input logic clr,
                          input logic [31:0] av, input logic [31:0] bv, input logic ordy);
        in_valid  = v;
        op        = o;
        acc_mode  = am;
        acc_clr   = clr;
        a         = av;
        b         = bv;
        out_ready = ordy;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_valid"},  {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        check({tag, "_result"}, result, m_last);
        check({tag, "_zero"},   {31'b0, zero},   {31'b0, m_last == 32'h0});
        check({tag, "_parity"}, {31'b0, parity}, {31'b0, ^m_last});
    endtask

    // Called at a falling edge with inputs already driven; models one rising
    // edge and checks the outputs at the next falling edge.
    task automatic cycle(input string tag);
        logic [31:0] r;
        logic        m_ready;
        logic        m_fire;
        #1;
        m_ready = (exp_q.size() == 0) || out_ready;
        check({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, m_ready});
        m_fire = in_valid && m_ready;
        r = ref_op(op, acc_mode ? m_acc : a, b);
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (m_fire) begin
            exp_q.push_back(r);
            m_last = r;
            if (acc_mode) m_acc = r;
        end else if (acc_clr) begin
            m_acc = ACC_INIT;
        end
        @(negedge clk);
        check_outs(tag);
    endtask

    logic [31:0] t2_exp[7];

    initial begin
        total  = 0;
        bad    = 0;
        m_acc  = ACC_INIT;
        m_last = 32'h0;
        t2_exp = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000,
                   32'hFF0F_FFF0, 32'h00FF_F00F, 32'hF000_00F0};

        // 1) reset
        rst = 1'b1;
        set_in(1'b0, OP_AND, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("rst_valid",  {31'b0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_zero",   {31'b0, zero}, 32'h1);
        check("rst_parity", {31'b0, parity}, 32'h0);
        check("rst_ready",  {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b1, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h5, 1'b1);
        cycle("t1");
        check("t1_pass", result, 32'h5);
        check("t1_par",  {31'b0, parity}, 32'h0);

        // 2) every op on fixed operands
        for (int i = 0; i < 7; i++) begin
            set_in(1'b1, i[2:0], 1'b0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1);
            cycle("t2");
            check("t2_op", result, t2_exp[i]);
        end

        // 3) backpressure
        set_in(1'b1, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h1, 1'b1);
        cycle("t3a");
        check("t3_first", result, 32'h1);
        set_in(1'b1, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("t3s");
            check("t3_hold",  result, 32'h1);
            check("t3_stall", {31'b0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        cycle("t3b");
        check("t3_next", result, 32'h2);
        set_in(1'b1, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h3, 1'b1);
        cycle("t3c");
        check("t3_nobub", result, 32'h3);

        // 4) accumulate
        set_in(1'b0, OP_OR, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        cycle("t4clr");
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'h1, 1'b1);
        cycle("t4");
        check("t4_r1", result, 32'h1);
        b = 32'h2;
        cycle("t4");
        check("t4_r2", result, 32'h3);
        b = 32'h8;
        cycle("t4");
        check("t4_r3", result, 32'hB);
        set_in(1'b1, OP_XOR, 1'b1, 1'b0, 32'h0, 32'hB, 1'b1);
        cycle("t4x");
        check("t4_xor",  result, 32'h0);
        check("t4_zero", {31'b0, zero}, 32'h1);

        // 5) clear colliding with a fire
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'hB, 1'b1);
        cycle("t5");
        set_in(1'b1, OP_OR, 1'b1, 1'b1, 32'h0, 32'h4, 1'b1);
        cycle("t5col");
        check("t5_col", result, 32'hF);
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("t5acc");
        check("t5_acc", result, 32'hF);
        set_in(1'b0, OP_OR, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1);
        cycle("t5idle");
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("t5clr");
        check("t5_cleared", result, 32'h0);

        // 6) reset in the middle of a stall
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'h55, 1'b1);
        cycle("t6a");
        set_in(1'b1, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h7, 1'b0);
        cycle("t6s");
        check("t6_stall", {31'b0, out_valid}, 32'h1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_valid",  {31'b0, out_valid}, 32'h0);
        check("t6_result", result, 32'h0);
        check("t6_zero",   {31'b0, zero}, 32'h1);
        check("t6_ready",  {31'b0, in_ready}, 32'h1);
        exp_q.delete();
        m_acc  = ACC_INIT;
        m_last = 32'h0;
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs("t6r");
        set_in(1'b0, OP_PASS, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("t6i");
        cycle("t6i");
        set_in(1'b1, OP_OR, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle("t6acc");
        check("t6_acc", result, ACC_INIT);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0,
                   $urandom, $urandom, $urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
